// File: rtl/dm_responder.sv
// dm_responder: multi-cycle data-memory responder for the CPU data port.
// Accepts one read or write at a time, stalls the core while the access is
// in flight and completes it LATENCY cycles after the accept edge with a
// one-cycle rsp_valid pulse. Storage is 2^DEPTH_LOG2 16-bit words and is not
// cleared by reset.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset
//   re        in   read request
//   we        in   write request (priority over re)
//   addr      in   16-bit word address
//   wdata     in   16-bit write data
//   rdata     out  registered read data, held until the next read response
//   rsp_valid out  one-cycle response pulse
//   stall     out  core must hold PC/request while high
//   err       out  out-of-range flag, pulses with rsp_valid
module dm_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rsp_valid,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Address bits above the array depth; any set bit means out of range.
  localparam logic [15:0] HI_MASK  = ~16'((32'd1 << DEPTH_LOG2) - 32'd1);
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;

  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        op_write_q;
  logic        oor_q;

  logic [15:0] mem [0:(1 << DEPTH_LOG2) - 1];

  logic        req;
  logic        accept;
  logic        commit;
  logic [15:0] c_addr;
  logic [15:0] c_wdata;
  logic        c_write;
  logic        c_oor;
  logic [DEPTH_LOG2-1:0] c_idx;

  assign req    = re | we;
  assign accept = (state == IDLE) && req;

  // The commit edge is the one entering RESP. With LATENCY=1 that is the
  // accept edge itself, so the live inputs must be used instead of the
  // latched copies.
  always_comb begin
    if (state == IDLE) begin
      c_addr  = addr;
      c_wdata = wdata;
      c_write = we;
    end else begin
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_write = op_write_q;
    end
  end

  assign c_oor  = |(c_addr & HI_MASK);
  assign c_idx  = c_addr[DEPTH_LOG2-1:0];
  assign commit = (state_next == RESP) && (state != RESP) && !rst;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign stall     = (state == WAIT) || ((state == IDLE) && req);
  assign rsp_valid = (state == RESP);
  assign err       = (state == RESP) && oor_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rdata      <= '0;
      oor_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        addr_q     <= addr;
        wdata_q    <= wdata;
        op_write_q <= we;
      end
      if (commit) begin
        oor_q <= c_oor;
        if (!c_write) begin
          rdata <= c_oor ? '0 : mem[c_idx];
        end
      end
    end
  end

  // Storage has no reset; commit already excludes the reset edge.
  always_ff @(posedge clk) begin
    if (commit && c_write && !c_oor) begin
      mem[c_idx] <= c_wdata;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Testbench for dm_responder: scoreboard of expected responses pushed when a
// request is driven and popped in the response cycle. Main instance uses
// LATENCY=4, a second instance uses LATENCY=1.
module tb_dm_responder;

  localparam int LAT = 4;
  localparam logic [15:0] HI_MASK = 16'hFF00;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        re, we;
  logic [15:0] addr, wdata;
  logic [15:0] rdata;
  logic        rsp_valid, stall, err;

  logic        re1, we1;
  logic [15:0] addr1, wdata1;
  logic [15:0] rdata1;
  logic        rsp_valid1, stall1, err1;

  int errors = 0;
  int checks = 0;

  exp_t        sbq[$];
  logic [15:0] mdl [0:255];
  logic [15:0] last_rdata;

  dm_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rsp_valid(rsp_valid), .stall(stall), .err(err)
  );

  dm_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .re(re1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .rsp_valid(rsp_valid1), .stall(stall1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a rising edge; returns just after the rising edge that
  // starts the IDLE cycle following RESP, so calls chain back-to-back.
  task automatic run_access(input logic w, input logic r, input logic [15:0] a,
                            input logic [15:0] d, input string name);
    exp_t e;
    exp_t got;
    logic o;
    o = (a & HI_MASK) != 16'h0;
    e.err = o;
    if (w) begin
      e.rdata = last_rdata;
      if (!o) mdl[a[7:0]] = d;
    end else begin
      e.rdata = o ? 16'h0000 : mdl[a[7:0]];
      last_rdata = e.rdata;
    end
    sbq.push_back(e);
    re = r; we = w; addr = a; wdata = d;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s cycle0 stall=%b rsp_valid=%b expected stall=1 rsp_valid=0",
               name, stall, rsp_valid);
    end
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0; addr = ~a; wdata = ~d;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT) begin
        checks++;
        if (stall !== 1'b1 || rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s wait cycle%0d stall=%b rsp_valid=%b expected stall=1 rsp_valid=0",
                   name, k, stall, rsp_valid);
        end
      end else begin
        got = sbq.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || stall !== 1'b0) begin
          errors++;
          $display("FAIL %s resp cycle rsp_valid=%b stall=%b expected rsp_valid=1 stall=0",
                   name, rsp_valid, stall);
        end
        checks++;
        if (rdata !== got.rdata) begin
          errors++;
          $display("FAIL %s rdata got %h expected %h", name, rdata, got.rdata);
        end
        checks++;
        if (err !== got.err) begin
          errors++;
          $display("FAIL %s err got %b expected %b", name, err, got.err);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    re1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdata !== 16'h0000) begin errors++; $display("FAIL reset rdata got %h expected 0000", rdata); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid got %b expected 0", rsp_valid); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset err got %b expected 0", err); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset stall got %b expected 0", stall); end
    rst = 1'b0;
    last_rdata = 16'h0000;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    run_access(1'b1, 1'b0, 16'h0010, 16'hBEEF, "wr_0010");
    run_access(1'b0, 1'b1, 16'h0010, 16'h0000, "rd_0010");
    run_access(1'b0, 1'b1, 16'h0042, 16'h0000, "rd_preload_0042");
  endtask

  task automatic test_latency1();
    exp_t e;
    exp_t got;
    e.rdata = 16'h1234;
    e.err   = 1'b0;
    sbq.push_back(e);
    re1 = 1'b1; addr1 = 16'h0003;
    @(negedge clk);
    checks++;
    if (stall1 !== 1'b1 || rsp_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1 cycle0 stall=%b rsp_valid=%b expected stall=1 rsp_valid=0", stall1, rsp_valid1);
    end
    @(posedge clk); #1;
    re1 = 1'b0; addr1 = 16'h00FF;
    @(negedge clk);
    got = sbq.pop_front();
    checks++;
    if (rsp_valid1 !== 1'b1 || stall1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1 resp rsp_valid=%b stall=%b expected rsp_valid=1 stall=0", rsp_valid1, stall1);
    end
    checks++;
    if (rdata1 !== got.rdata || err1 !== got.err) begin
      errors++;
      $display("FAIL lat1 rdata/err got %h/%b expected %h/%b", rdata1, err1, got.rdata, got.err);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1 after resp rsp_valid got %b expected 0", rsp_valid1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    run_access(1'b1, 1'b0, 16'h0100, 16'hAAAA, "oor_wr_0100");
    run_access(1'b0, 1'b1, 16'h0000, 16'h0000, "rd_0000_after_oor");
    run_access(1'b0, 1'b1, 16'h0100, 16'h0000, "oor_rd_0100");
    run_access(1'b0, 1'b1, 16'h8001, 16'h0000, "oor_rd_8001");
  endtask

  task automatic test_both();
    run_access(1'b0, 1'b1, 16'h0007, 16'h0000, "rd_0007");
    run_access(1'b1, 1'b1, 16'h0005, 16'h5555, "both_0005");
    run_access(1'b0, 1'b1, 16'h0005, 16'h0000, "rd_0005");
  endtask

  task automatic test_mid_reset();
    re = 1'b0; we = 1'b1; addr = 16'h0020; wdata = 16'h7777;
    @(posedge clk); #1;
    we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL midrst wait2 stall got %b expected 1", stall); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_rdata = 16'h0000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || stall !== 1'b0 || rdata !== 16'h0000) begin
        errors++;
        $display("FAIL midrst idle%0d rsp_valid=%b stall=%b rdata=%h expected 0/0/0000",
                 k, rsp_valid, stall, rdata);
      end
      @(posedge clk); #1;
    end
    run_access(1'b0, 1'b1, 16'h0020, 16'h0000, "rd_0020_after_rst");
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    for (int n = 0; n < 12; n++) begin
      a = 16'($urandom_range(0, 16'h01FF));
      run_access(1'b1, 1'b0, a, 16'($urandom), "b2b_wr");
      run_access(1'b0, 1'b1, a, 16'h0000, "b2b_raw");
      a = 16'($urandom_range(0, 16'h01FF));
      run_access(1'b0, 1'b1, a, 16'h0000, "b2b_rd");
    end
  endtask

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    re1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    last_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      mdl[i]     = 16'hC000 | 16'(i);
      dut.mem[i] = 16'hC000 | 16'(i);
    end
    dut1.mem[3] = 16'h1234;
    test_reset();
    test_write_read();
    test_latency1();
    test_out_of_range();
    test_both();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
